sram_rr_arbiter: RTL and testbench

- Shares one single-port synchronous RAM among n_req requesters. The RAM has a 1-cycle read latency and write-first addressing.
- Round-robin arbitration; at most one access is issued per cycle.
- Drives the RAM we/address/data_in ports and routes the RAM data_out back to the requesters with a per-requester read-valid strobe.
- Sits between processing units and the shared buffer RAM.

---
 rtl/sram_arb_pkg.sv | 34 +++
 rtl/rr_pick.sv | 29 ++
 rtl/sram_rr_arbiter.sv | 114 +++++++++++
 tb/tb_sram_rr_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and the round-robin scan used by the SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_win_t;

    // Scan ptr+1, ptr+2, ... modulo n. Iterating from the far end lets the
    // nearest requester overwrite, so the last hit is the winner.
    function automatic rr_win_t next_rr(input logic [MAX_REQ-1:0] req,
                                        input logic [IDX_W-1:0]   ptr,
                                        input int                 n);
        rr_win_t win;
        int      j;
        win = '0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                j = (int'(ptr) + k) % n;
                if (req[j[IDX_W-1:0]]) begin
                    win.valid = 1'b1;
                    win.idx   = j[IDX_W-1:0];
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: masked requests in, one-hot grant and index out.
module rr_pick
    import sram_arb_pkg::*;
#(
    parameter int n_req = 4
) (
    input  logic [n_req-1:0] req,
    input  logic [n_req-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [n_req-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    rr_win_t            win;
    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext              = '0;
        req_ext[n_req-1:0]   = req & mask;
        win                  = next_rr(req_ext, ptr, n_req);
        valid                = win.valid;
        idx                  = win.idx;
        gnt                  = '0;
        for (int i = 0; i < n_req; i++)
            gnt[i] = win.valid && (win.idx == IDX_W'(i));
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among n_req requesters.
// Optional grant locking is built when ARB_LOCK_EN is defined.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int d_width = 8,
    parameter int a_width = 8,
    parameter int n_req   = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [n_req-1:0]           req,
    input  logic [n_req-1:0]           we,
    input  logic [n_req*a_width-1:0]   addr,
    input  logic [n_req*d_width-1:0]   wdata,
    input  logic [n_req-1:0]           lock,
    output logic [n_req-1:0]           ack,
    output logic [n_req-1:0]           rvalid,
    output logic [d_width-1:0]         rdata,
    output logic                       ram_we,
    output logic [a_width-1:0]         ram_addr,
    output logic [d_width-1:0]         ram_din,
    input  logic [d_width-1:0]         ram_dout
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] g_idx;
    logic             g_valid;
    logic [n_req-1:0] mask;
    arb_state_t       state;

    rr_pick #(.n_req(n_req)) u_pick (
        .req   (req),
        .mask  (mask),
        .ptr   (ptr),
        .gnt   (ack),
        .idx   (g_idx),
        .valid (g_valid)
    );

    // Zero-default mux keeps the RAM ports quiet on an idle bus.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        for (int i = 0; i < n_req; i++) begin
            if (ack[i]) begin
                ram_we   = we[i];
                ram_addr = addr[i*a_width +: a_width];
                ram_din  = wdata[i*d_width +: d_width];
            end
        end
    end

    assign rdata = ram_dout;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr    <= IDX_W'(n_req - 1);
            rvalid <= '0;
        end else begin
            rvalid <= ack & ~we;
            if (g_valid && state == IDLE)
                ptr <= g_idx;
        end
    end

`ifdef ARB_LOCK_EN
    // state  | meaning
    // IDLE   | plain round-robin among all requesters
    // LOCKED | only owner may be granted, pointer frozen
    logic [IDX_W-1:0] owner;
    logic             owner_lock;

    always_comb begin
        owner_lock = 1'b0;
        mask       = '1;
        for (int i = 0; i < n_req; i++) begin
            if (owner == IDX_W'(i))
                owner_lock = lock[i];
            if (state == LOCKED)
                mask[i] = (owner == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            owner <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (g_valid && lock[g_idx]) begin
                        state <= LOCKED;
                        owner <= g_idx;
                    end
                end
                LOCKED: begin
                    if (!owner_lock)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_lock;

    assign state       = IDLE;
    assign mask        = '1;
    assign unused_lock = ^lock;
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed-vector bench for sram_rr_arbiter with a behavioural write-first RAM.
module tb_sram_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            nrst;
    logic [N-1:0]    req, we, lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    ack, rvalid;
    logic [DW-1:0]   rdata;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_din, ram_dout;
    logic [DW-1:0]   mem [256];

    int vectors    = 0;
    int miscompares = 0;

    sram_rr_arbiter #(.d_width(DW), .a_width(AW), .n_req(N)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .lock     (lock),
        .ack      (ack),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_din;
        ram_dout <= ram_we ? ram_din : mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]               = r;
        we[i]                = w;
        addr[i*AW +: AW]     = a;
        wdata[i*DW +: DW]    = d;
    endtask

    logic [N-1:0] lock_exp [4];

    initial begin
        nrst  = 1'b0;
        req   = '0;
        we    = '0;
        lock  = '0;
        addr  = '0;
        wdata = '0;

        #12;
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        cyc();
        nrst = 1'b1;

        // write 0xA5 to 0x10, then read it back
        cyc();
        set_port(0, 1'b1, 1'b1, 8'h10, 8'hA5);
        #1;
        chk("wr_ack", 32'(ack), 32'h1);
        chk("wr_ram_we", 32'(ram_we), 32'h1);
        chk("wr_ram_addr", 32'(ram_addr), 32'h10);
        chk("wr_ram_din", 32'(ram_din), 32'hA5);
        cyc();
        chk("wr_no_rvalid", 32'(rvalid), 32'h0);
        set_port(0, 1'b1, 1'b0, 8'h10, 8'h00);
        #1;
        chk("rd_ack", 32'(ack), 32'h1);
        chk("rd_ram_we", 32'(ram_we), 32'h0);
        chk("rd_ram_addr", 32'(ram_addr), 32'h10);
        chk("rd_ram_din", 32'(ram_din), 32'h0);
        cyc();
        chk("rd_rvalid", 32'(rvalid), 32'h1);
        chk("rd_rdata", 32'(rdata), 32'hA5);
        req = '0;
        #1;
        chk("rd_drop_ack", 32'(ack), 32'h0);

        // reset priority: all four reading, expect 0,1,2,3,0
        nrst = 1'b0;
        #1;
        nrst = 1'b1;
        for (int i = 0; i < N; i++)
            set_port(i, 1'b1, 1'b0, 8'h10, 8'h00);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("prio_ack%0d", k), 32'(ack), 32'(1 << (k % 4)));
            cyc();
            chk($sformatf("prio_rvalid%0d", k), 32'(rvalid), 32'(1 << (k % 4)));
            chk($sformatf("prio_rdata%0d", k), 32'(rdata), 32'hA5);
        end
        req = '0;

        // two-way contention between ports 1 and 3 (writes to 0x20)
        set_port(1, 1'b1, 1'b1, 8'h20, 8'h11);
        set_port(3, 1'b1, 1'b1, 8'h20, 8'h33);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("cont_ack%0d", k), 32'(ack), (k % 2 == 0) ? 32'h2 : 32'h8);
            chk($sformatf("cont_we%0d", k), 32'(ram_we), 32'h1);
            cyc();
            chk($sformatf("cont_rvalid%0d", k), 32'(rvalid), 32'h0);
        end

        // idle bus with stale we/addr/wdata still driven
        req = '0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("idle_ack%0d", k), 32'(ack), 32'h0);
            chk($sformatf("idle_we%0d", k), 32'(ram_we), 32'h0);
            chk($sformatf("idle_addr%0d", k), 32'(ram_addr), 32'h0);
            chk($sformatf("idle_din%0d", k), 32'(ram_din), 32'h0);
            cyc();
        end
        // ptr held at 3, so port 0 beats port 2
        we  = '0;
        req = 4'b0101;
        #1;
        chk("idle_ptr_held", 32'(ack), 32'h1);
        cyc();
        req = 4'b0100;
        #1;
        chk("single_req2", 32'(ack), 32'h4);
        cyc();
        req = '0;

        // reset across the edge that would raise rvalid
        set_port(1, 1'b1, 1'b0, 8'h10, 8'h00);
        #1;
        chk("mid_ack", 32'(ack), 32'h2);
        #1;
        nrst = 1'b0;
        cyc();
        chk("mid_rvalid_rst", 32'(rvalid), 32'h0);
        #2;
        nrst = 1'b1;
        #1;
        chk("mid_rvalid_rel", 32'(rvalid), 32'h0);
        req = '0;
        cyc();
        chk("mid_rvalid_after", 32'(rvalid), 32'h0);
        req = 4'b0101;
        #1;
        chk("mid_ptr_reset", 32'(ack), 32'h1);
        cyc();
        req = '0;

        // locking: port 0 locks for two cycles, releases in the third
`ifdef ARB_LOCK_EN
        lock_exp[0] = 4'b0001; lock_exp[1] = 4'b0001;
        lock_exp[2] = 4'b0001; lock_exp[3] = 4'b0010;
`else
        lock_exp[0] = 4'b0001; lock_exp[1] = 4'b0010;
        lock_exp[2] = 4'b0001; lock_exp[3] = 4'b0010;
`endif
        nrst = 1'b0;
        #1;
        nrst = 1'b1;
        set_port(0, 1'b1, 1'b1, 8'h30, 8'h01);
        set_port(1, 1'b1, 1'b1, 8'h31, 8'h02);
        lock = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            if (k == 2)
                lock = '0;
            #1;
            chk($sformatf("lock_ack%0d", k), 32'(ack), 32'(lock_exp[k]));
            cyc();
        end
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
